display_scan_driver: RTL and testbench

- Receiving end of the processor's 8-bit `display` output bus.
- Converts the unsigned byte to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 3-digit common-anode seven-segment display.
- Sits at the top level between the processor core and the board pins.

---
 rtl/display_scan_driver.sv | 133 +++++++++++++
 tb/tb_display_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// display_scan_driver: byte-to-BCD double-dabble converter driving a 3-digit multiplexed common-anode display
module display_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZB = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shown_q, shown_d, sreg_q, sreg_d, cap_q, cap_d;
  logic [11:0]   acc_q, acc_d, acc_adj, bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit;
  logic          last, blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // add-3 correction of every accumulator nibble that would overflow a decimal digit when doubled
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 3; i++)
      acc_adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end

  // converter FSM: capture a changed byte, shift it through eight add-3/shift steps, publish the result
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    sreg_d  = sreg_q;
    cap_d   = cap_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (value != shown_q) begin
        cap_d   = value;
        sreg_d  = value;
        acc_d   = '0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {acc_d, sreg_d} = {acc_adj[10:0], sreg_q, 1'b0};
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = acc_q;
        shown_d = cap_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // scan timing and registered digit/segment drive from the currently selected slot
  always_comb begin
    last  = ref_q == CW'(REFRESH_DIV - 1);
    ref_d = last ? '0 : ref_q + 1'b1;
    idx_d = last ? (idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1) : idx_q;
    digit = idx_q == 2'd0 ? bcd_q[3:0] : idx_q == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
    blank = LZB && ((idx_q == 2'd2 && bcd_q[11:8] == 4'd0) || (idx_q == 2'd1 && bcd_q[11:4] == 8'd0));
    an_d  = ~(3'b001 << idx_q);
    seg_d = blank ? 7'b1111111 : decode(digit);
  end

  // state registers; asynchronous reset aborts any conversion in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shown_q <= '0;
      sreg_q  <= '0;
      cap_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= 3'b111;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      sreg_q  <= sreg_d;
      cap_q   <= cap_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign an   = an_q;
  assign seg  = seg_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: randomized self-checking bench against an arithmetic reference of conversion and scanning
module tb_display_scan_driver;
  logic        clk = 1'b0, reset = 1'b0;
  logic [7:0]  value = 8'd0;
  logic        busy1, busy0;
  logic [11:0] bcd1, bcd0;
  logic [2:0]  an1, an0;
  logic [6:0]  seg1, seg0;
  int          checks = 0, passed = 0, cyc = 0;
  logic [7:0]  last_v = 8'd0;
  logic [6:0]  dec [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  display_scan_driver #(.REFRESH_DIV(4), .LZB(1'b1)) u1 (
    .clk(clk), .reset(reset), .value(value), .busy(busy1), .bcd(bcd1), .an(an1), .seg(seg1));
  display_scan_driver #(.REFRESH_DIV(4), .LZB(1'b0)) u0 (
    .clk(clk), .reset(reset), .value(value), .busy(busy0), .bcd(bcd0), .an(an0), .seg(seg0));

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset;
    logic saw = 1'b0;
    reset = 1'b0;
    value = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (an1 !== 3'b111) $display("FAIL reset_an got %b want 111", an1); else passed++;
    checks++; if (seg1 !== 7'h7f) $display("FAIL reset_seg got %b want 1111111", seg1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else passed++;
    checks++; if (bcd1 !== 12'h000) $display("FAIL reset_bcd got %h want 000", bcd1); else passed++;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy1 !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw || bcd1 !== 12'h000) $display("FAIL zero_no_conv busy_seen %b bcd %h want 0/000", saw, bcd1); else passed++;
  endtask

  task automatic test_latency(input logic [7:0] v);
    logic [11:0] prev;
    prev = bcd1;
    value = v;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b1 || bcd1 !== prev)
        $display("FAIL latency_busy v=%0d cyc%0d busy %b bcd %h want 1/%h", v, i, busy1, bcd1, prev);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || bcd1 !== model_bcd(v) || busy0 !== 1'b0 || bcd0 !== model_bcd(v))
      $display("FAIL latency_done v=%0d busy %b bcd %h/%h want 0/%h", v, busy1, bcd1, bcd0, model_bcd(v));
    else passed++;
    last_v = v;
  endtask

  task automatic test_scan(input logic [7:0] v);
    int d [3];
    int k, j;
    logic [2:0] ea;
    logic [6:0] e1, e0;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = v / 100;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      k  = cyc;
      j  = ((k - 1) / 4) % 3;
      ea = ~(3'(1) << j);
      e0 = dec[d[j]];
      e1 = ((j == 2 && v < 100) || (j == 1 && v < 10)) ? 7'h7f : e0;
      checks++;
      if (an1 !== ea || an0 !== ea) $display("FAIL scan_an v=%0d k=%0d got %b/%b want %b", v, k, an1, an0, ea);
      else passed++;
      checks++;
      if (seg1 !== e1) $display("FAIL scan_seg_lzb v=%0d slot %0d got %b want %b", v, j, seg1, e1);
      else passed++;
      checks++;
      if (seg0 !== e0) $display("FAIL scan_seg_nolzb v=%0d slot %0d got %b want %b", v, j, seg0, e0);
      else passed++;
    end
  endtask

  task automatic test_return_zero;
    test_latency(8'd255);
    test_scan(8'd255);
    test_latency(8'd0);
    test_scan(8'd0);
  endtask

  task automatic test_busy_change;
    value = 8'd100;
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) $display("FAIL chg_capture busy %b want 1", busy1); else passed++;
    repeat (3) @(negedge clk);
    value = 8'd42;
    for (int i = 0; i < 20 && busy1 !== 1'b0; i++) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || bcd1 !== 12'h100) $display("FAIL chg_first busy %b bcd %h want 0/100", busy1, bcd1);
    else passed++;
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) $display("FAIL chg_restart busy %b want 1", busy1); else passed++;
    repeat (9) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || bcd1 !== 12'h042) $display("FAIL chg_second busy %b bcd %h want 0/042", busy1, bcd1);
    else passed++;
    last_v = 8'd42;
  endtask

  task automatic test_reset_mid;
    logic partial = 1'b0;
    value = 8'd200;
    @(negedge clk);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (an1 !== 3'b111 || seg1 !== 7'h7f || busy1 !== 1'b0 || bcd1 !== 12'h000)
      $display("FAIL mid_reset an %b seg %b busy %b bcd %h want 111/1111111/0/000", an1, seg1, busy1, bcd1);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) $display("FAIL mid_restart busy %b want 1", busy1); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bcd1 !== 12'h000) partial = 1'b1;
    end
    checks++; if (partial) $display("FAIL mid_partial bcd changed early got %h want 000", bcd1); else passed++;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || bcd1 !== 12'h200) $display("FAIL mid_result busy %b bcd %h want 0/200", busy1, bcd1);
    else passed++;
    last_v = 8'd200;
  endtask

  task automatic test_random;
    logic [7:0] v;
    for (int n = 0; n < 6; n++) begin
      v = 8'($urandom_range(0, 255));
      if (v == last_v) v = v + 8'd1;
      test_latency(v);
      test_scan(v);
    end
  endtask

  initial begin
    test_reset;
    test_return_zero;
    test_latency(8'd7);
    test_scan(8'd7);
    test_busy_change;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
